alu_ctrl_seq: RTL
=================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter CTRL_W, default 4, ALU control word width; legal range 4..8.
REQ-002 Parameter MUL_EN, default 1; 1 enables multi-cycle multiply decode, 0 disables it.
REQ-003 Parameter MUL_OP, default 5'b00010, opcode of the multi-cycle multiply instruction.
REQ-004 Parameter MUL_CYCLES, default 4, multiply occupancy in cycles; legal range 1..16.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous kill of any held or in-flight decode.
REQ-008 in_valid  input  1  OpCode/Funct valid.
REQ-009 in_ready  output  1  block can accept a decode this cycle.
REQ-010 OpCode  input  5  instruction opcode.
REQ-011 Funct  input  2  instruction function field.
REQ-012 out_valid  output  1  ALU_Ctrl holds a completed decode.
REQ-013 out_ready  input  1  consumer takes ALU_Ctrl this cycle.
REQ-014 ALU_Ctrl  output  CTRL_W  registered ALU control word.
REQ-015 mul_busy  output  1  multiply sequence in progress.
REQ-016 mul_step  output  1  high in every MUL-state cycle, one multiply iteration per cycle.

Function
REQ-017 Decode table (4-bit code, zero-extended to CTRL_W): 0000 = op 01000 | (11011,Funct 01); 0010 = 01010 | (11011,11); 0011 = 01011 | (11011,10); 0100..0111 = ops 10100..10111 | (11010,Funct 00..11) respectively.
REQ-018 Decode continued: 11001->1000, 11100->1001, 11101->1010, 11110->1011, 11111->1100, 11000->1101, 10010->1110.
REQ-019 OpCode == MUL_OP with MUL_EN=1 SHALL decode to 1111 and be a multiply; every other input, including MUL_OP with MUL_EN=0, SHALL decode to 0001.
REQ-020 Acceptance occurs at a rising edge with in_valid & in_ready; decode is combinational on the accepted inputs and captured into ALU_Ctrl at that edge.
REQ-021 FSM states IDLE, MUL, HOLD; reset state IDLE.
REQ-022 IDLE: in_ready=1; non-multiply accept, or multiply with MUL_CYCLES=1, -> HOLD; multiply with MUL_CYCLES>=2 -> MUL with counter=1.
REQ-023 MUL: in_ready=0, out_valid=0, mul_busy=1, mul_step=1; each edge: counter==MUL_CYCLES-1 -> HOLD, else counter+1.
REQ-024 HOLD: out_valid=1; ALU_Ctrl stable until out_ready.
REQ-025 HOLD: in_ready=out_ready, enabling back-to-back transfer; on out_ready with accept -> next decode per REQ-022 rules, on out_ready without accept -> IDLE.
REQ-026 Latency: non-multiply out_valid 1 cycle after acceptance; multiply out_valid MUL_CYCLES cycles after acceptance.
REQ-027 Throughput: one non-multiply decode per cycle when out_ready is held high.
REQ-028 ALU_Ctrl SHALL change only at acceptance edges and otherwise hold its last value.
REQ-029 flush=1 (rst=0) SHALL force IDLE, clear the counter, and drop out_valid/mul_busy next cycle, ignoring any same-cycle accept; ALU_Ctrl retains its value.
REQ-030 Priority: rst > flush > handshake.
REQ-031 Counter width SHALL be 4 bits and SHALL never exceed MUL_CYCLES-1.

Reset
REQ-032 rst=1 at an edge SHALL set state IDLE, counter 0, ALU_Ctrl 0, out_valid 0, mul_busy 0, mul_step 0; in_ready reads 1 the next cycle.
REQ-033 Reset mid-multiply or mid-HOLD SHALL discard the operation with no later out_valid.

Verification
REQ-034 Op 01000 accepted, out_ready=1 -> next cycle out_valid=1, ALU_Ctrl=0000; then IDLE.
REQ-035 Stream 10100, (11010,01), 11111 on consecutive cycles, out_ready=1 -> ALU_Ctrl 0100, 0101, 1100 on consecutive cycles, in_ready never low.
REQ-036 MUL_OP, MUL_CYCLES=4 -> mul_step high 3 cycles, in_ready=0 during them, out_valid=1 with 1111 on cycle 4.
REQ-037 HOLD with out_ready=0 for 5 cycles -> ALU_Ctrl/out_valid stable, in_ready=0; new input not accepted.
REQ-038 flush during MUL cycle 2 -> next cycle IDLE, mul_busy=0, no out_valid; rst during HOLD -> ALU_Ctrl=0, out_valid=0.
REQ-039 MUL_EN=0, MUL_OP accepted -> 1 cycle later ALU_Ctrl=0001, mul_step never asserted.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: decode request/response handshake bus for alu_ctrl_seq
interface alu_ctrl_if #(parameter int CTRL_W = 4);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [4:0] OpCode;
  logic [1:0] Funct;
  logic out_valid;
  logic out_ready;
  logic [CTRL_W-1:0] ALU_Ctrl;
  logic mul_busy;
  logic mul_step;
  modport master(output flush, in_valid, OpCode, Funct, out_ready, input in_ready, out_valid, ALU_Ctrl, mul_busy, mul_step);
  modport slave(input flush, in_valid, OpCode, Funct, out_ready, output in_ready, out_valid, ALU_Ctrl, mul_busy, mul_step);
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with multi-cycle multiply sequencing
module alu_ctrl_seq #(
  parameter int CTRL_W = 4,
  parameter bit MUL_EN = 1'b1,
  parameter logic [4:0] MUL_OP = 5'b00010,
  parameter int MUL_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  alu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  localparam logic [3:0] LAST = 4'(MUL_CYCLES - 1);
  localparam bit MULTI = MUL_CYCLES > 1;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [3:0] code;
  logic is_mul;
  logic accept;
  assign is_mul = MUL_EN && bus.OpCode == MUL_OP;
  assign bus.in_ready = state_q == IDLE || (state_q == HOLD && bus.out_ready);
  assign bus.out_valid = state_q == HOLD;
  assign bus.mul_busy = state_q == MUL;
  assign bus.mul_step = state_q == MUL;
  assign bus.ALU_Ctrl = ctrl_q;
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    code = 4'b0001;
    if (bus.OpCode == MUL_OP)
      code = MUL_EN ? 4'b1111 : 4'b0001;
    else
      case (bus.OpCode)
        5'b01000: code = 4'b0000;
        5'b01010: code = 4'b0010;
        5'b01011: code = 4'b0011;
        5'b10100, 5'b10101, 5'b10110, 5'b10111: code = {2'b01, bus.OpCode[1:0]};
        5'b11010: code = {2'b01, bus.Funct};
        5'b11011: code = bus.Funct == 2'b01 ? 4'b0000 : bus.Funct == 2'b11 ? 4'b0010 : bus.Funct == 2'b10 ? 4'b0011 : 4'b0001;
        5'b11001: code = 4'b1000;
        5'b11100: code = 4'b1001;
        5'b11101: code = 4'b1010;
        5'b11110: code = 4'b1011;
        5'b11111: code = 4'b1100;
        5'b11000: code = 4'b1101;
        5'b10010: code = 4'b1110;
        default: code = 4'b0001;
      endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ctrl_d = ctrl_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == MUL) begin
      state_d = cnt_q == LAST ? HOLD : MUL;
      cnt_d = cnt_q == LAST ? 4'd0 : cnt_q + 4'd1;
    end else if (accept) begin
      ctrl_d = CTRL_W'(code);
      state_d = is_mul && MULTI ? MUL : HOLD;
      cnt_d = is_mul && MULTI ? 4'd1 : 4'd0;
    end else if (state_q == HOLD && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
    end
  end
endmodule
